// File: rtl/regfile_dbg.sv
// Parametrised integer register file with write-to-read bypass, out-of-range guarding
// and a valid/ready debug dump port that streams every architectural register.
module regfile_dbg #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 16,
    parameter int unsigned AW    = 5
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    input  logic [AW-1:0]   A3,
    input  logic            WE3,
    input  logic [XLEN-1:0] WD3,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    input  logic            dbg_start,
    input  logic            dbg_ready,
    output logic            dbg_valid,
    output logic [AW-1:0]   dbg_idx,
    output logic [XLEN-1:0] dbg_data,
    output logic            dbg_busy,
    output logic            dbg_done
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StSend = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [AW:0]   NRegsW  = (AW+1)'(NREGS);
    localparam logic [AW-1:0] LastIdx = AW'(NREGS - 1);

    // x0 has no storage; entries start at index 1.
    logic [XLEN-1:0] regs_q [1:NREGS-1];

    logic [1:0]      state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            wr_en;

    function automatic logic in_range(input logic [AW-1:0] a);
        return (a != '0) && ({1'b0, a} < NRegsW);
    endfunction

    assign wr_en = WE3 && in_range(A3);

    // Post-write view of register a: bypasses a same-cycle write.
    function automatic logic [XLEN-1:0] read_reg(input logic [AW-1:0] a);
        logic [XLEN-1:0] v;
        v = '0;
        if (in_range(a)) begin
            if (wr_en && (A3 == a)) begin
                v = WD3;
            end else begin
                for (int unsigned i = 1; i < NREGS; i++) begin
                    if (a == AW'(i)) v = regs_q[i];
                end
            end
        end
        return v;
    endfunction

    always_comb begin
        RD1 = read_reg(A1);
        RD2 = read_reg(A2);
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 1; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            for (int unsigned i = 1; i < NREGS; i++) begin
                if (wr_en && (A3 == AW'(i))) regs_q[i] <= WD3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            StIdle: begin
                if (dbg_start) begin
                    state_d = StSend;
                    idx_d   = '0;
                    data_d  = '0;
                end
            end
            StSend: begin
                if (dbg_ready) begin
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d  = idx_q + AW'(1);
                        data_d = read_reg(idx_q + AW'(1));
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    assign dbg_valid = (state_q == StSend);
    assign dbg_busy  = (state_q != StIdle);
    assign dbg_done  = (state_q == StDone);
    assign dbg_idx   = idx_q;
    assign dbg_data  = data_q;

endmodule

// File: tb/tb_regfile_dbg.sv
// Randomised bench for regfile_dbg: compares reads and dump beats against an array model
// of the architectural registers.
module tb_regfile_dbg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 16;
    localparam int unsigned AW    = 5;

    logic            CLK = 1'b0;
    logic            reset = 1'b0;
    logic [AW-1:0]   A1 = '0, A2 = '0, A3 = '0;
    logic            WE3 = 1'b0;
    logic [XLEN-1:0] WD3 = '0;
    logic [XLEN-1:0] RD1, RD2;
    logic            dbg_start = 1'b0, dbg_ready = 1'b0;
    logic            dbg_valid, dbg_busy, dbg_done;
    logic [AW-1:0]   dbg_idx;
    logic [XLEN-1:0] dbg_data;

    int vectors    = 0;
    int miscompares = 0;

    logic [XLEN-1:0] model [NREGS];

    regfile_dbg #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
        .CLK(CLK), .reset(reset),
        .A1(A1), .A2(A2), .A3(A3), .WE3(WE3), .WD3(WD3),
        .RD1(RD1), .RD2(RD2),
        .dbg_start(dbg_start), .dbg_ready(dbg_ready), .dbg_valid(dbg_valid),
        .dbg_idx(dbg_idx), .dbg_data(dbg_data), .dbg_busy(dbg_busy), .dbg_done(dbg_done)
    );

    always #5 CLK = ~CLK;

    function automatic logic [XLEN-1:0] rd_ref(input logic [AW-1:0] a);
        if (a == 0 || a >= NREGS) return '0;
        if (WE3 && A3 == a) return WD3;
        return model[a];
    endfunction

    task automatic model_edge();
        if (WE3 && A3 != 0 && A3 < NREGS) model[A3] = WD3;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) model[i] = '0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        WE3 = 1'b1; A3 = 5'd3; WD3 = 32'h77;
        @(posedge CLK);
        #2 reset = 1'b1;
        A1 = 5'd3; A2 = 5'd15; WE3 = 1'b0;
        #1;
        model_clear();
        vectors++;
        if (RD1 !== '0 || RD2 !== '0) begin
            miscompares++;
            $display("FAIL reset_rd: got RD1=%h RD2=%h expected 0 0", RD1, RD2);
        end
        vectors++;
        if ({dbg_valid, dbg_busy, dbg_done} !== 3'b000 || dbg_idx !== '0 || dbg_data !== '0) begin
            miscompares++;
            $display("FAIL reset_dbg: got v/b/d=%b idx=%0d data=%h expected 000 0 0",
                     {dbg_valid, dbg_busy, dbg_done}, dbg_idx, dbg_data);
        end
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b0;
    endtask

    task automatic test_bypass();
        @(negedge CLK);
        WE3 = 1'b1; A3 = 5'd5; WD3 = 32'hDEADBEEF; A1 = 5'd5; A2 = 5'd0;
        #1;
        vectors++;
        if (RD1 !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL bypass: got %h expected deadbeef", RD1);
        end
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        WE3 = 1'b0;
        #1;
        vectors++;
        if (RD1 !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL stored: got %h expected deadbeef", RD1);
        end
    endtask

    task automatic test_x0_oor();
        logic [AW-1:0] addrs [2];
        addrs[0] = 5'd0;
        addrs[1] = 5'd20;
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            WE3 = 1'b1; A3 = addrs[k]; WD3 = 32'h1234; A1 = 5'd0; A2 = 5'd20;
            #1;
            vectors++;
            if (RD1 !== '0 || RD2 !== '0) begin
                miscompares++;
                $display("FAIL x0_oor_write: got RD1=%h RD2=%h expected 0 0", RD1, RD2);
            end
            @(posedge CLK);
            model_edge();
        end
        @(negedge CLK);
        WE3 = 1'b0;
        for (int i = 1; i < NREGS; i++) begin
            A1 = AW'(i);
            #1;
            vectors++;
            if (RD1 !== model[i]) begin
                miscompares++;
                $display("FAIL unchanged_reg%0d: got %h expected %h", i, RD1, model[i]);
            end
        end
    endtask

    task automatic test_random_rw();
        logic [XLEN-1:0] e1, e2;
        for (int n = 0; n < 150; n++) begin
            @(negedge CLK);
            WE3 = 1'($urandom_range(0, 1));
            A3  = AW'($urandom_range(0, 31));
            WD3 = $urandom;
            A1  = ($urandom_range(0, 3) == 0) ? A3 : AW'($urandom_range(0, 31));
            A2  = ($urandom_range(0, 3) == 0) ? A1 : AW'($urandom_range(0, 31));
            #1;
            e1 = rd_ref(A1);
            e2 = rd_ref(A2);
            vectors++;
            if (RD1 !== e1 || RD2 !== e2) begin
                miscompares++;
                $display("FAIL rand_rd: A1=%0d A2=%0d got %h %h expected %h %h",
                         A1, A2, RD1, RD2, e1, e2);
            end
            @(posedge CLK);
            model_edge();
        end
        @(negedge CLK);
        WE3 = 1'b0;
    endtask

    task automatic test_preload();
        for (int i = 1; i < NREGS; i++) begin
            @(negedge CLK);
            WE3 = 1'b1; A3 = AW'(i); WD3 = 32'h100 + XLEN'(i);
            @(posedge CLK);
            model_edge();
        end
        @(negedge CLK);
        WE3 = 1'b0;
    endtask

    // mode 0: ready high, no writes; 1: directed stall/capture; 2: random; 3: reset at beat 7
    task automatic run_dump(input int mode);
        int              beat, stall, busy_cycles;
        bit              finished, aborted;
        logic [XLEN-1:0] cap, e1, e2;
        @(negedge CLK);
        dbg_start = 1'b1; WE3 = 1'b0; dbg_ready = 1'b0;
        @(posedge CLK);
        beat = 0; cap = '0; stall = 0; busy_cycles = 0; finished = 0; aborted = 0;
        @(negedge CLK);
        dbg_start = 1'b0;
        for (int cyc = 0; cyc < 400 && !finished && !aborted; cyc++) begin
            vectors++;
            if ({dbg_valid, dbg_busy, dbg_done} !== 3'b110 || dbg_idx !== AW'(beat)
                || dbg_data !== cap) begin
                miscompares++;
                $display("FAIL beat%0d: got v/b/d=%b idx=%0d data=%h expected 110 %0d %h",
                         beat, {dbg_valid, dbg_busy, dbg_done}, dbg_idx, dbg_data, beat, cap);
            end
            if (mode == 1 && (beat == 4 || beat == 5)) begin
                vectors++;
                if (dbg_data !== ((beat == 4) ? 32'h104 : 32'h5555)) begin
                    miscompares++;
                    $display("FAIL capture_beat%0d: got %h expected %h", beat, dbg_data,
                             (beat == 4) ? 32'h104 : 32'h5555);
                end
            end
            busy_cycles++;
            WE3 = 1'b0; dbg_ready = 1'b1; dbg_start = 1'b0;
            if (mode == 1) begin
                dbg_start = (beat == 2);
                if (beat == 4 && stall < 3) begin
                    dbg_ready = 1'b0; WE3 = 1'b1; A3 = 5'd4; WD3 = 32'hAAAA;
                    stall++;
                end else if (beat == 4) begin
                    WE3 = 1'b1; A3 = 5'd5; WD3 = 32'h5555;
                end
            end else if (mode == 2) begin
                dbg_ready = ($urandom_range(0, 3) != 0);
                dbg_start = 1'($urandom_range(0, 1));
                WE3 = 1'($urandom_range(0, 1));
                A3  = AW'($urandom_range(0, NREGS + 2));
                WD3 = $urandom;
            end
            A1 = AW'($urandom_range(0, 31));
            A2 = (mode == 2) ? A3 : AW'($urandom_range(0, 31));
            #1;
            e1 = rd_ref(A1);
            e2 = rd_ref(A2);
            vectors++;
            if (RD1 !== e1 || RD2 !== e2) begin
                miscompares++;
                $display("FAIL dump_rd: got %h %h expected %h %h", RD1, RD2, e1, e2);
            end
            if (mode == 3 && beat == 7) begin
                #1 reset = 1'b1;
                #1;
                vectors++;
                if ({dbg_valid, dbg_busy, dbg_done} !== 3'b000) begin
                    miscompares++;
                    $display("FAIL abort: got v/b/d=%b expected 000",
                             {dbg_valid, dbg_busy, dbg_done});
                end
                model_clear();
                aborted = 1;
            end else begin
                @(posedge CLK);
                model_edge();
                if (dbg_ready) begin
                    if (beat == NREGS - 1) begin
                        finished = 1;
                    end else begin
                        beat++;
                        cap = model[beat];
                    end
                end
                @(negedge CLK);
            end
        end
        WE3 = 1'b0; dbg_ready = 1'b0; dbg_start = 1'b0;
        if (aborted) begin
            @(negedge CLK);
            @(negedge CLK);
            reset = 1'b0;
            for (int k = 0; k < 2; k++) begin
                @(negedge CLK);
                vectors++;
                if ({dbg_valid, dbg_busy, dbg_done} !== 3'b000) begin
                    miscompares++;
                    $display("FAIL after_abort: got v/b/d=%b expected 000",
                             {dbg_valid, dbg_busy, dbg_done});
                end
            end
        end else if (!finished) begin
            vectors++;
            miscompares++;
            $display("FAIL dump_timeout: got beat %0d expected %0d", beat, NREGS - 1);
        end else begin
            busy_cycles++;
            vectors++;
            if ({dbg_valid, dbg_busy, dbg_done} !== 3'b011) begin
                miscompares++;
                $display("FAIL done: got v/b/d=%b expected 011",
                         {dbg_valid, dbg_busy, dbg_done});
            end
            @(negedge CLK);
            vectors++;
            if ({dbg_valid, dbg_busy, dbg_done} !== 3'b000) begin
                miscompares++;
                $display("FAIL idle_after_done: got v/b/d=%b expected 000",
                         {dbg_valid, dbg_busy, dbg_done});
            end
            if (mode == 0) begin
                vectors++;
                if (busy_cycles != NREGS + 1) begin
                    miscompares++;
                    $display("FAIL busy_cycles: got %0d expected %0d", busy_cycles, NREGS + 1);
                end
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_bypass();
        test_x0_oor();
        test_random_rw();
        test_preload();
        run_dump(0);
        run_dump(1);
        run_dump(3);
        run_dump(0);
        test_random_rw();
        for (int r = 0; r < 3; r++) run_dump(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_dbg.md
# regfile_dbg

Parametrised integer register file for the P_Risc core with asynchronous clear, write-to-read bypass, out-of-range address guarding, and a valid/ready debug dump port that streams every architectural register to the SPI debug bridge. It sits between decode (read addresses), writeback (write port) and the SPI debug unit. It is the drop-in successor to the fixed 16×32 file, generalised in width and depth.

## Interface
Parameters:
- XLEN, 32, data width of each register
- NREGS, 16, number of architectural registers including x0 (2..32)
- AW, 5, register address width; NREGS ≤ 2^AW

Ports:
- CLK  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all registers and dump FSM
- A1  in  AW  read address port 1 (rs1)
- A2  in  AW  read address port 2 (rs2)
- A3  in  AW  write address (rd)
- WE3  in  1  write enable
- WD3  in  XLEN  write data
- RD1  out  XLEN  read data port 1, combinational
- RD2  out  XLEN  read data port 2, combinational
- dbg_start  in  1  request a full dump; sampled only in IDLE
- dbg_ready  in  1  sink ready for current dump beat
- dbg_valid  out  1  dump beat valid
- dbg_idx  out  AW  register index of current beat
- dbg_data  out  XLEN  register value of current beat
- dbg_busy  out  1  dump in progress (state ≠ IDLE)
- dbg_done  out  1  one-cycle pulse after last beat accepted

## Operation
- Storage: registers 1..NREGS-1, XLEN bits each. x0 not stored; always reads 0.
- Reset: all stored registers → 0; state → IDLE; dbg_valid, dbg_busy, dbg_done → 0; dbg_idx, dbg_data → 0. Reset mid-dump aborts with no dbg_done.
- Write: at rising edge, if WE3 && A3 ≠ 0 && A3 < NREGS, reg[A3] ← WD3. Writes to x0 or A3 ≥ NREGS are silently dropped.
- Read: RDn = 0 if An == 0 or An ≥ NREGS; else if WE3 && A3 == An && A3 ≠ 0, RDn = WD3 (bypass); else reg[An]. Both ports obey identical rules; A1 == A2 is legal.
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE: dbg_start=1 at edge → SEND, beat 0 loaded (dbg_idx=0, dbg_data=0).
  - SEND: dbg_valid=1. On edge with dbg_ready=1: if dbg_idx == NREGS-1 → DONE; else dbg_idx+1, dbg_data loaded with that register. dbg_ready=0: hold idx and data unchanged.
  - DONE: dbg_done=1, dbg_valid=0, dbg_busy=1 for one cycle → IDLE.
- Beat capture: the value loaded into dbg_data for index i at an edge is the post-write value of reg[i] at that edge (a same-edge write to i is included). Writes to i after capture do not alter the held beat.
- dbg_start while busy: ignored. Register reads/writes fully independent of dump; no stall of the core.

## Timing
- Write latency: 1 edge to storage; 0 cycles to RD via bypass.
- dbg_valid rises 1 cycle after dbg_start is sampled in IDLE.
- Full dump with dbg_ready held high: NREGS SEND cycles + 1 DONE cycle; dbg_busy high NREGS+1 cycles.
- dbg_valid/dbg_idx/dbg_data are registered outputs, stable while dbg_valid && !dbg_ready.
- dbg_done is registered, high exactly one cycle per completed dump.
- Earliest new dbg_start accepted: the cycle after DONE (state IDLE).

## Test plan
- Reset then read: assert reset async mid-cycle; A1=3, A2=15 → RD1=RD2=0; dbg_busy=0, dbg_valid=0 immediately.
- Write/read + bypass: WE3=1, A3=5, WD3=0xDEADBEEF, A1=5 same cycle → RD1=0xDEADBEEF combinationally; next cycle WE3=0 → RD1 still 0xDEADBEEF.
- x0 and out-of-range: write 0x1234 to A3=0 and, with NREGS=16, to A3=20 → RD of A=0 and A=20 return 0; regs 1..15 unchanged.
- Full dump: preload reg[i]=0x100+i, pulse dbg_start, dbg_ready=1 → beats idx 0..15 with data 0,0x101..0x10F on consecutive cycles, then dbg_done high one cycle, total 17 busy cycles.
- Backpressure + capture: during dump stall dbg_ready=0 at idx 4 for 3 cycles while writing reg[4]=0xAAAA → dbg_data stays 0x104; write reg[5]=0x5555 at the accept edge of beat 4 → beat 5 shows 0x5555.
- Reset mid-dump and restart: assert reset at idx 7 → valid/busy drop, no dbg_done; dbg_start during busy ignored; new dbg_start after reset → dump begins at idx 0 with all-zero data.
